// File: rtl/microroc_sc_pkg.sv
// MICROROC slow-control serializer: shared states, defaults and helpers.
// Imported by the serializer top and its shift-clock generator.
package microroc_sc_pkg;

  localparam int SC_BITS_DEF     = 592;
  localparam int RS_BITS_DEF     = 64;
  localparam int ASIC_NUMBER_DEF = 4;
  localparam int CLK_DIV_DEF     = 4;
  localparam int RST_CYCLES_DEF  = 8;
  localparam int CHIPID_LSB_DEF  = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_END   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int wbits(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/microroc_sc_serializer_sr_clock_generator.sv
// Shift-clock phase generator: CLK_DIV cycles low, CLK_DIV cycles high,
// with a strobe on the final cycle of each high phase.
module sr_clock_generator
  import microroc_sc_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sr_ck,
  output logic bit_adv
);

  localparam int CW = wbits(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase_end;

  assign phase_end = enable && (cnt == LAST);
  assign bit_adv   = phase_end && sr_ck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      sr_ck <= 1'b0;
    end else if (!enable) begin
      cnt   <= '0;
      sr_ck <= 1'b0;
    end else if (phase_end) begin
      cnt   <= '0;
      sr_ck <= ~sr_ck;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microroc_sc_serializer.sv
// Loads slow-control or read-scope images into a daisy-chained ASIC string,
// inserting a per-ASIC ChipID into each slow-control copy.
module microroc_sc_serializer
  import microroc_sc_pkg::*;
#(
  parameter int SC_BITS     = SC_BITS_DEF,
  parameter int RS_BITS     = RS_BITS_DEF,
  parameter int ASIC_NUMBER = ASIC_NUMBER_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter int CHIPID_LSB  = CHIPID_LSB_DEF
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               LoadStart,
  input  logic               SlowOrReadScopeSelect,
  input  logic [SC_BITS-1:0] SlowControlVector,
  input  logic [RS_BITS-1:0] ReadScopeVector,
  input  logic [7:0]         ChipIdBase,
  output logic               SrIn,
  output logic               SrCk,
  output logic               SrRstb,
  output logic               SelectSlowControl,
  output logic               Busy,
  output logic               LoadDone
);

  localparam int MAXB = max2(SC_BITS, RS_BITS);
  localparam int PW   = wbits(MAXB);
  localparam int BW   = $clog2(ASIC_NUMBER * SC_BITS + 1);
  localparam int TW   = wbits(max2(RST_CYCLES, CLK_DIV));

  localparam logic [PW-1:0] SC_LAST  = PW'(SC_BITS - 1);
  localparam logic [PW-1:0] RS_LAST  = PW'(RS_BITS - 1);
  localparam logic [BW-1:0] N_SC     = BW'(ASIC_NUMBER * SC_BITS);
  localparam logic [BW-1:0] N_RS     = BW'(ASIC_NUMBER * RS_BITS);
  localparam logic [TW-1:0] CLR_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] END_LAST = TW'(CLK_DIV - 1);
  localparam logic [7:0]    TOP_OFS  = 8'(ASIC_NUMBER - 1);

  // Left-aligned copy image so the next bit is always the MSB.
  function automatic logic [MAXB-1:0] build(
    input logic               m,
    input logic [SC_BITS-1:0] sc,
    input logic [RS_BITS-1:0] rs,
    input logic [7:0]         id
  );
    logic [SC_BITS-1:0] s;
    logic [MAXB-1:0]    r;
    s = sc;
    s[CHIPID_LSB +: 8] = id;
    r = '0;
    if (m) r[MAXB-1 -: SC_BITS] = s;
    else   r[MAXB-1 -: RS_BITS] = rs;
    return r;
  endfunction

  logic [2:0]         state;
  logic               mode;
  logic [SC_BITS-1:0] sc_sh;
  logic [RS_BITS-1:0] rs_sh;
  logic [7:0]         chip;
  logic [MAXB-1:0]    wk;
  logic [PW-1:0]      pos;
  logic [BW-1:0]      bcnt;
  logic [TW-1:0]      tmr;
  logic               sr_in;

  logic               shift_en;
  logic               bit_adv;
  logic [BW-1:0]      n_last;
  logic [7:0]         chip_nx;
  logic [7:0]         chip_first;
  logic [7:0]         chip_step;
  logic [PW-1:0]      pos_step;
  logic [MAXB-1:0]    wk_step;

  assign shift_en   = (state == ST_SHIFT);
  assign n_last     = mode ? (N_SC - 1'b1) : (N_RS - 1'b1);
  assign chip_first = ChipIdBase + TOP_OFS;

  sr_clock_generator #(
    .CLK_DIV(CLK_DIV)
  ) u_srck (
    .clk    (Clk),
    .reset  (reset),
    .enable (shift_en),
    .sr_ck  (SrCk),
    .bit_adv(bit_adv)
  );

  // Copy boundary: rebuild the image for the next ASIC down the chain.
  always_comb begin
    chip_nx   = chip - 8'd1;
    wk_step   = wk << 1;
    pos_step  = pos - 1'b1;
    chip_step = chip;
    if (pos == '0) begin
      wk_step   = build(mode, sc_sh, rs_sh, chip_nx);
      pos_step  = mode ? SC_LAST : RS_LAST;
      chip_step = chip_nx;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      mode  <= 1'b0;
      sc_sh <= '0;
      rs_sh <= '0;
      chip  <= '0;
      wk    <= '0;
      pos   <= '0;
      bcnt  <= '0;
      tmr   <= '0;
      sr_in <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (LoadStart) begin
            state <= ST_CLEAR;
            mode  <= SlowOrReadScopeSelect;
            sc_sh <= SlowControlVector;
            rs_sh <= ReadScopeVector;
            chip  <= chip_first;
            wk    <= build(SlowOrReadScopeSelect,
                           SlowControlVector,
                           ReadScopeVector,
                           chip_first);
            pos   <= SlowOrReadScopeSelect ? SC_LAST : RS_LAST;
            bcnt  <= '0;
            tmr   <= '0;
          end
        end
        ST_CLEAR: begin
          if (tmr == CLR_LAST) begin
            state <= ST_SHIFT;
            tmr   <= '0;
            sr_in <= wk[MAXB-1];
            wk    <= wk_step;
            pos   <= pos_step;
            chip  <= chip_step;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_adv) begin
            if (bcnt == n_last) begin
              state <= ST_END;
              sr_in <= 1'b0;
            end else begin
              bcnt  <= bcnt + 1'b1;
              sr_in <= wk[MAXB-1];
              wk    <= wk_step;
              pos   <= pos_step;
              chip  <= chip_step;
            end
          end
        end
        ST_END: begin
          if (tmr == END_LAST) begin
            state <= ST_DONE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign SrIn              = sr_in;
  assign SrRstb            = (state != ST_CLEAR);
  assign SelectSlowControl = mode;
  assign LoadDone          = (state == ST_DONE);
  assign Busy              = (state == ST_CLEAR) ||
                             (state == ST_SHIFT) ||
                             (state == ST_END);

endmodule

// File: tb/tb_microroc_sc_serializer.sv
// Randomized self-checking bench for microroc_sc_serializer against a
// stream model built directly from the image/ChipID rules.
module tb_microroc_sc_serializer;

  localparam int SCB = 592;
  localparam int RSB = 64;
  localparam int AN  = 4;
  localparam int D   = 4;
  localparam int R   = 8;
  localparam int LSB = 8;
  localparam int LIMIT = 25000;

  logic           clk = 1'b0;
  logic           reset;
  logic           load_start;
  logic           sel;
  logic [SCB-1:0] scv;
  logic [RSB-1:0] rsv;
  logic [7:0]     base;
  logic           sr_in, sr_ck, sr_rstb, sel_sc, busy, load_done;

  always #5 clk = ~clk;

  microroc_sc_serializer #(
    .SC_BITS(SCB), .RS_BITS(RSB), .ASIC_NUMBER(AN),
    .CLK_DIV(D), .RST_CYCLES(R), .CHIPID_LSB(LSB)
  ) dut (
    .Clk                  (clk),
    .reset                (reset),
    .LoadStart            (load_start),
    .SlowOrReadScopeSelect(sel),
    .SlowControlVector    (scv),
    .ReadScopeVector      (rsv),
    .ChipIdBase           (base),
    .SrIn                 (sr_in),
    .SrCk                 (sr_ck),
    .SrRstb               (sr_rstb),
    .SelectSlowControl    (sel_sc),
    .Busy                 (busy),
    .LoadDone             (load_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit   cap[$];
  bit   exp_q[$];
  logic exp_mode;
  int   busy_n, rstb_n, done_n, hi_bad, hold_bad;
  bit   timed_out, aborted;

  task automatic rand_vecs();
    for (int i = 0; i < SCB; i++) scv[i] = 1'($urandom);
    rsv  = {$urandom, $urandom};
    base = 8'($urandom);
  endtask

  // Expected stream: AN copies MSB first, copy k aimed at ASIC AN-1-k.
  task automatic make_exp();
    exp_q.delete();
    exp_mode = sel;
    for (int k = 0; k < AN; k++) begin
      logic [7:0] id;
      id = 8'(int'(base) + AN - 1 - k);
      if (sel) begin
        for (int i = SCB - 1; i >= 0; i--)
          exp_q.push_back((i >= LSB && i < LSB + 8) ? id[i-LSB] : scv[i]);
      end else begin
        for (int i = RSB - 1; i >= 0; i--) exp_q.push_back(rsv[i]);
      end
    end
  endtask

  task automatic run_load(input int toggle_cyc, input int pulse_cyc,
                          input bit pulse_done, input int abort_bit);
    int  cyc, post, hi_run, dn;
    bit  prev, rise_val;
    cap.delete();
    busy_n = 0; rstb_n = 0; done_n = 0; hi_bad = 0; hold_bad = 0;
    timed_out = 0; aborted = 0; prev = 0; hi_run = 0; rise_val = 0;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("acc_busy", 64'(busy), 64'd1);
    check("acc_rstb", 64'(sr_rstb), 64'd0);
    check("acc_sel", 64'(sel_sc), 64'(exp_mode));
    cyc = 1;
    post = 0;
    while (post < 12 && !aborted) begin
      if (busy) busy_n++;
      if (!sr_rstb) rstb_n++;
      if (load_done) done_n++;
      if (sr_ck) begin
        hi_run++;
        if (!prev) begin
          cap.push_back(sr_in);
          rise_val = sr_in;
        end else if (sr_in !== rise_val) hold_bad++;
      end else if (prev) begin
        if (hi_run != D) hi_bad++;
        hi_run = 0;
      end
      prev = sr_ck;
      if (done_n > 0) post++;
      load_start = 1'b0;
      if (cyc == toggle_cyc) begin
        rand_vecs();
        sel = ~sel;
      end
      if (cyc == pulse_cyc) load_start = 1'b1;
      if (pulse_done && load_done) load_start = 1'b1;
      if (abort_bit >= 0 && cap.size() == abort_bit) begin
        aborted = 1;
        #2 reset = 1'b1;
        #1 check("abort_outs",
                 64'({sr_in, sr_ck, sr_rstb, sel_sc, busy, load_done}),
                 64'b001000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (load_done || busy) dn++;
        end
        check("abort_quiet", 64'(dn), 64'd0);
      end else begin
        if (cyc >= LIMIT) begin
          timed_out = 1;
          post = 12;
        end
        @(negedge clk);
      end
      cyc++;
    end
    load_start = 1'b0;
  endtask

  task automatic verify(input string tag);
    int mism, n;
    n = exp_q.size();
    mism = 0;
    for (int i = 0; i < n && i < cap.size(); i++)
      if (cap[i] != exp_q[i]) mism++;
    check({tag, "_timeout"}, 64'(timed_out), 64'd0);
    check({tag, "_edges"}, 64'(cap.size()), 64'(n));
    check({tag, "_stream"}, 64'(mism), 64'd0);
    check({tag, "_busy"}, 64'(busy_n), 64'(R + 2 * D * n + D));
    check({tag, "_rstb"}, 64'(rstb_n), 64'(R));
    check({tag, "_done"}, 64'(done_n), 64'd1);
    check({tag, "_hi_len"}, 64'(hi_bad), 64'd0);
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_sel_hold"}, 64'(sel_sc), 64'(exp_mode));
  endtask

  initial begin
    logic [7:0] ids [4];
    logic [7:0] f;
    int idx;
    ids = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    reset = 1'b1;
    load_start = 1'b0;
    sel = 1'b0;
    scv = '0;
    rsv = '0;
    base = '0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          64'({sr_in, sr_ck, sr_rstb, sel_sc, busy, load_done}),
          64'b001000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Read-scope marker pattern.
    rand_vecs();
    sel = 1'b0;
    rsv = 64'h8000_0000_0000_0001;
    make_exp();
    run_load(-1, -1, 1'b0, -1);
    verify("rs_dir");
    check("rs_dir_n", 64'(cap.size()), 64'd256);

    // Slow-control with ChipID wrap, ignored LoadStart in SHIFT and DONE.
    rand_vecs();
    sel = 1'b1;
    base = 8'hFE;
    make_exp();
    run_load(-1, 3000, 1'b1, -1);
    verify("sc_dir");
    check("sc_dir_n", 64'(cap.size()), 64'd2368);
    for (int k = 0; k < AN; k++) begin
      f = '0;
      for (int b = 0; b < 8; b++) begin
        idx = k * SCB + (SCB - 1 - (LSB + b));
        if (idx < cap.size()) f[b] = cap[idx];
      end
      check($sformatf("chipid_%0d", k), 64'(f), 64'(ids[k]));
    end

    // Random read-scope loads with inputs scrambled mid-SHIFT.
    for (int i = 0; i < 2; i++) begin
      rand_vecs();
      sel = 1'b0;
      make_exp();
      run_load(300 + 100 * i, 500, 1'b0, -1);
      verify($sformatf("rs_tog%0d", i));
    end

    // Abort a slow-control load at bit 100.
    rand_vecs();
    sel = 1'b1;
    make_exp();
    run_load(-1, -1, 1'b0, 100);
    check("abort_hit", 64'(aborted), 64'd1);
    idx = 0;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] != exp_q[i]) idx++;
    check("abort_prefix", 64'(idx), 64'd0);

    // Full slow-control load after the abort, inputs scrambled mid-SHIFT.
    rand_vecs();
    sel = 1'b1;
    make_exp();
    run_load(5000, -1, 1'b0, -1);
    verify("sc_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/microroc_sc_serializer.md
MICROROC_SC_SERIALIZER -- requirements
Module: microroc_sc_serializer

Interface
REQ-001 Parameter SC_BITS, default 592: slow-control register length per ASIC.
REQ-002 Parameter RS_BITS, default 64: read-scope register length per ASIC.
REQ-003 Parameter ASIC_NUMBER, default 4: ASICs daisy-chained on one chain.
REQ-004 Parameter CLK_DIV, default 4: SrCk half-period in Clk cycles, at least 1.
REQ-005 Parameter RST_CYCLES, default 8: SrRstb low duration in Clk cycles, at least 1.
REQ-006 Parameter CHIPID_LSB, default 8: LSB position of the 8-bit ChipID field in the SC vector.
REQ-007 Clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 LoadStart  in  1  single-cycle load request from the per-chain parameter distribution stage.
REQ-010 SlowOrReadScopeSelect  in  1  1 = slow-control load, 0 = read-scope load.
REQ-011 SlowControlVector  in  SC_BITS  assembled slow-control image, bit SC_BITS-1 shifted first.
REQ-012 ReadScopeVector  in  RS_BITS  read-scope image, bit RS_BITS-1 shifted first.
REQ-013 ChipIdBase  in  8  ChipID of the ASIC nearest the FPGA.
REQ-014 SrIn  out  1  serial data to the ASIC chain.
REQ-015 SrCk  out  1  shift clock; the ASIC samples SrIn on the SrCk rising edge.
REQ-016 SrRstb  out  1  active-low shift-register reset to the ASIC chain.
REQ-017 SelectSlowControl  out  1  ASIC register select, latched mode.
REQ-018 Busy  out  1  high while a load is in progress.
REQ-019 LoadDone  out  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, CLEAR, SHIFT, END and DONE.
REQ-021 LoadStart SHALL be accepted only in IDLE and ignored in every other state, including DONE.
REQ-022 On acceptance, the module SHALL latch the mode, both vectors and ChipIdBase into shadow registers; later input changes SHALL NOT affect the stream.
REQ-023 One cycle after acceptance, the module SHALL be in CLEAR with Busy=1, SrRstb=0 and SelectSlowControl=latched mode.
REQ-024 CLEAR SHALL last RST_CYCLES cycles, then go to SHIFT with SrRstb=1.
REQ-025 The total bit count N SHALL be ASIC_NUMBER*SC_BITS in slow-control mode and ASIC_NUMBER*RS_BITS in read-scope mode.
REQ-026 Each bit SHALL occupy 2*CLK_DIV cycles: SrIn updated with SrCk low for CLK_DIV cycles, then SrCk high for CLK_DIV cycles; SrIn is stable across the rising edge.
REQ-027 The image SHALL be shifted ASIC_NUMBER times, MSB first; copy k (k=0 first) is destined for ASIC ASIC_NUMBER-1-k.
REQ-028 In slow-control mode, the field [CHIPID_LSB+7:CHIPID_LSB] of copy k SHALL carry (ChipIdBase + ASIC_NUMBER-1-k) mod 256.
REQ-029 No ChipID substitution SHALL occur in read-scope mode.
REQ-030 The bit counter width SHALL be clog2 of ASIC_NUMBER*SC_BITS+1; no wrap SHALL occur within a load.
REQ-031 After the last high phase, SrCk SHALL return low and END SHALL hold for CLK_DIV cycles.
REQ-032 DONE SHALL last one cycle with LoadDone=1 and Busy=0, then return to IDLE.
REQ-033 Busy duration SHALL be RST_CYCLES + 2*CLK_DIV*N + CLK_DIV cycles (2060 for read-scope and 18956 for slow-control at defaults).
REQ-034 SelectSlowControl SHALL hold its latched value until the next accepted load.

Reset
REQ-035 reset SHALL asynchronously force IDLE, SrIn=0, SrCk=0, SrRstb=1, SelectSlowControl=0, Busy=0 and LoadDone=0, and clear all counters.
REQ-036 A reset mid-load SHALL abort the load without a LoadDone pulse; the next LoadStart SHALL restart from CLEAR.

Structure
REQ-037 Package microroc_sc_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-038 One sub-module, sr_clock_generator, SHALL produce the CLK_DIV phase timing and a per-bit advance strobe.

Verification
REQ-039 Read-scope mode, ReadScopeVector=64'h8000_0000_0000_0001 -> 256 SrCk rising edges sampling the pattern 4x, Busy 2060 cycles, one LoadDone pulse.
REQ-040 Slow-control mode, ChipIdBase=8'hFE -> captured ChipID fields 8'h01, 8'h00, 8'hFF, 8'hFE for copies 0..3, all other bits match the vector, 2368 edges.
REQ-041 LoadStart pulsed during SHIFT and in the DONE cycle -> ignored, edge count and timing unchanged.
REQ-042 Vectors and mode toggled mid-SHIFT -> captured stream identical to the image latched at start.
REQ-043 reset asserted at bit 100 -> outputs at reset values immediately, no LoadDone; a subsequent LoadStart produces a complete, correct load.
